// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control FSM driving the alucontrol/alu/regfile
// datapath. Accepts one 16-bit register-register instruction per valid/ready
// handshake and walks it through DECODE, EXECUTE and WRITEBACK.
// Instruction fields: [15:12] aluop, [11:8] Rdest, [7:4] opext, [3:0] Rsrc.
// Optional build macro RETIRE_CNT_EN adds a 16-bit retired-instruction counter.
module alu_sequencer #(
  parameter int          REG_AW = 4,
  parameter logic [3:0]  OP_CMP = 4'b1011,
  parameter logic [3:0]  OP_NOP = 4'b0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [REG_AW-1:0] ra1,
  output logic [REG_AW-1:0] ra2,
  output logic [REG_AW-1:0] wa,
  output logic              regwrite,
  output logic [3:0]        aluop,
  output logic [3:0]        opext,
  input  logic [4:0]        psr_in,
  output logic [4:0]        psr_q,
  output logic              done
`ifdef RETIRE_CNT_EN
  ,
  output logic [15:0]       retire_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [4:0]  psr_d;

  // Datapath controls are plain fields of the latched instruction, so they
  // only move at the accept edge and stay put through the following IDLE.
  assign aluop = instr_q[15:12];
  assign opext = instr_q[7:4];
  assign ra1   = REG_AW'(instr_q[3:0]);
  assign ra2   = REG_AW'(instr_q[11:8]);
  assign wa    = REG_AW'(instr_q[11:8]);

  // Next-state, instruction/flag capture and state-decoded strobes
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    psr_d       = psr_q;
    instr_ready = 1'b0;
    regwrite    = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = EXECUTE;
      end
      EXECUTE: begin
        if (instr_q[15:12] != OP_NOP) begin
          psr_d = psr_in;
        end
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        done     = 1'b1;
        regwrite = (instr_q[15:12] != OP_CMP) && (instr_q[15:12] != OP_NOP);
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, instruction and flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      psr_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      psr_q   <= psr_d;
    end
  end

`ifdef RETIRE_CNT_EN
  logic [15:0] retire_cnt_q, retire_cnt_d;

  assign retire_cnt = retire_cnt_q;

  // Count retirements; wraps naturally at 16 bits
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (done) begin
      retire_cnt_d = retire_cnt_q + 16'd1;
    end
  end

  // Retire counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end
`endif

endmodule
